// File: rtl/shapool_supervisor_pkg.sv
// Shared types for the shapool job supervisor: FSM state encoding and result word sizing.
package shapool_supervisor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NONCE_W = 32;

  function automatic int result_w(input int match_w);
    return match_w + NONCE_W;
  endfunction

endpackage

// File: rtl/shapool_supervisor_result_fifo.sv
// Synchronous result FIFO with flush; push while full is accepted only if a pop frees a slot.
module shapool_supervisor_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

endmodule

// File: rtl/shapool_supervisor.sv
// Job sequencer for the shapool: holds the pool in reset, releases it for a bounded sweep,
// buffers matches and reports job state through READY and a status LED.
module shapool_supervisor
  import shapool_supervisor_pkg::*;
#(
  parameter int              POOL_SIZE_LOG2 = 1,
  parameter int              MATCH_W        = 8,
  parameter int              RESET_CYCLES   = 4,
  parameter longint unsigned SWEEP_CYCLES   = (64'd1 << (32 - POOL_SIZE_LOG2)) + 64'd67,
  parameter int              RESULT_DEPTH   = 4,
  parameter int              LED_DIV_LOG2   = 22
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  input  logic                              job_load_in,
  input  logic                              job_abort_in,
  input  logic                              stop_on_match_in,
  input  logic                              pool_success_in,
  input  logic [NONCE_W-1:0]                pool_nonce_in,
  input  logic [MATCH_W-1:0]                pool_flags_in,
  output logic                              core_reset_n_out,
  output logic                              result_valid_out,
  output logic [MATCH_W+NONCE_W-1:0]        result_data_out,
  input  logic                              result_pop_in,
  output logic [$clog2(RESULT_DEPTH):0]     result_count_out,
  output logic                              overflow_out,
  output logic                              busy_out,
  output logic                              ready_out,
  output logic                              status_led_n_out
);

  localparam int RW = result_w(MATCH_W);
  localparam int SW = $clog2(SWEEP_CYCLES + 64'd1);
  localparam int FW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_CYCLES - 64'd1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RESET_CYCLES - 1);

  state_t              state;
  logic [FW-1:0]       flush_cnt;
  logic [SW-1:0]       sweep_cnt;
  logic                stop_mode;
  logic [LED_DIV_LOG2:0] led_div;
  logic                push;
  logic                drop;
  logic                fifo_full;

  assign push      = pool_success_in && (state == RUN);
  assign ready_out = (state == DONE) || result_valid_out;

  shapool_supervisor_result_fifo #(
    .WIDTH (RW),
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .flush (job_load_in),
    .push  (push),
    .pop   (result_pop_in),
    .din   ({pool_flags_in, pool_nonce_in}),
    .valid (result_valid_out),
    .dout  (result_data_out),
    .count (result_count_out),
    .full  (fifo_full),
    .drop  (drop)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) overflow_out <= 1'b0;
    else if (job_load_in) overflow_out <= 1'b0;
    else if (drop) overflow_out <= 1'b1;
  end

  // Outputs are assigned on the transition edge so they track the state they belong to.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      sweep_cnt        <= '0;
      stop_mode        <= 1'b0;
      led_div          <= '0;
      core_reset_n_out <= 1'b0;
      busy_out         <= 1'b0;
      status_led_n_out <= 1'b1;
    end else begin
      led_div <= led_div + 1'b1;
      if (job_load_in) begin
        state            <= FLUSH;
        flush_cnt        <= FLUSH_LAST;
        stop_mode        <= stop_on_match_in;
        core_reset_n_out <= 1'b0;
        busy_out         <= 1'b1;
        status_led_n_out <= ~led_div[LED_DIV_LOG2];
      end else begin
        case (state)
          FLUSH: begin
            if (job_abort_in) begin
              state            <= DONE;
              busy_out         <= 1'b0;
              status_led_n_out <= 1'b0;
            end else begin
              status_led_n_out <= ~led_div[LED_DIV_LOG2];
              if (flush_cnt == '0) begin
                state            <= RUN;
                sweep_cnt        <= '0;
                core_reset_n_out <= 1'b1;
              end else begin
                flush_cnt <= flush_cnt - 1'b1;
              end
            end
          end
          RUN: begin
            if (job_abort_in || (sweep_cnt == SWEEP_LAST) || (stop_mode && pool_success_in)) begin
              state            <= DONE;
              core_reset_n_out <= 1'b0;
              busy_out         <= 1'b0;
              status_led_n_out <= 1'b0;
            end else begin
              sweep_cnt        <= sweep_cnt + 1'b1;
              status_led_n_out <= ~led_div[LED_DIV_LOG2];
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_shapool_supervisor.sv
// Directed bench for shapool_supervisor with RESET_CYCLES=4, SWEEP_CYCLES=16, RESULT_DEPTH=4.
module tb_shapool_supervisor;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        job_load_in;
  logic        job_abort_in;
  logic        stop_on_match_in;
  logic        pool_success_in;
  logic [31:0] pool_nonce_in;
  logic [7:0]  pool_flags_in;
  logic        core_reset_n_out;
  logic        result_valid_out;
  logic [39:0] result_data_out;
  logic        result_pop_in;
  logic [2:0]  result_count_out;
  logic        overflow_out;
  logic        busy_out;
  logic        ready_out;
  logic        status_led_n_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  shapool_supervisor #(
    .POOL_SIZE_LOG2 (1),
    .MATCH_W        (8),
    .RESET_CYCLES   (4),
    .SWEEP_CYCLES   (64'd16),
    .RESULT_DEPTH   (4),
    .LED_DIV_LOG2   (2)
  ) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .job_load_in      (job_load_in),
    .job_abort_in     (job_abort_in),
    .stop_on_match_in (stop_on_match_in),
    .pool_success_in  (pool_success_in),
    .pool_nonce_in    (pool_nonce_in),
    .pool_flags_in    (pool_flags_in),
    .core_reset_n_out (core_reset_n_out),
    .result_valid_out (result_valid_out),
    .result_data_out  (result_data_out),
    .result_pop_in    (result_pop_in),
    .result_count_out (result_count_out),
    .overflow_out     (overflow_out),
    .busy_out         (busy_out),
    .ready_out        (ready_out),
    .status_led_n_out (status_led_n_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_core"},  64'(core_reset_n_out), 64'd0);
    chk({tag, "_valid"}, 64'(result_valid_out), 64'd0);
    chk({tag, "_data"},  64'(result_data_out),  64'd0);
    chk({tag, "_count"}, 64'(result_count_out), 64'd0);
    chk({tag, "_ovf"},   64'(overflow_out),     64'd0);
    chk({tag, "_busy"},  64'(busy_out),         64'd0);
    chk({tag, "_ready"}, 64'(ready_out),        64'd0);
    chk({tag, "_led"},   64'(status_led_n_out), 64'd1);
  endtask

  // Load a job and advance to the first RUN cycle (sweep counter 0).
  task automatic load_job(input logic stop);
    stop_on_match_in = stop;
    job_load_in      = 1'b1;
    step();
    job_load_in      = 1'b0;
    repeat (4) step();
  endtask

  task automatic strobe(input logic [31:0] nonce, input logic [7:0] flags, input logic pop);
    pool_success_in = 1'b1;
    pool_nonce_in   = nonce;
    pool_flags_in   = flags;
    result_pop_in   = pop;
    step();
    pool_success_in = 1'b0;
    result_pop_in   = 1'b0;
  endtask

  task automatic pop_one();
    result_pop_in = 1'b1;
    step();
    result_pop_in = 1'b0;
  endtask

  initial begin
    int low_cnt;
    int high_cnt;
    int led_toggles;
    logic led_prev;

    reset_n_in       = 1'b0;
    job_load_in      = 1'b0;
    job_abort_in     = 1'b0;
    stop_on_match_in = 1'b0;
    pool_success_in  = 1'b0;
    pool_nonce_in    = '0;
    pool_flags_in    = '0;
    result_pop_in    = 1'b0;
    repeat (2) @(negedge clk_in);
    check_reset("rst");
    reset_n_in = 1'b1;
    step();

    // Full sweep timing.
    stop_on_match_in = 1'b0;
    job_load_in = 1'b1;
    step();
    job_load_in = 1'b0;
    chk("flush_busy", 64'(busy_out), 64'd1);
    low_cnt = 0;
    for (int g = 0; g < 40 && core_reset_n_out == 1'b0; g++) begin
      low_cnt++;
      step();
    end
    chk("flush_low_cycles", 64'(low_cnt), 64'd4);
    high_cnt = 0;
    led_toggles = 0;
    led_prev = status_led_n_out;
    for (int g = 0; g < 40 && core_reset_n_out == 1'b1; g++) begin
      high_cnt++;
      if (status_led_n_out !== led_prev) led_toggles++;
      led_prev = status_led_n_out;
      step();
    end
    chk("run_high_cycles", 64'(high_cnt), 64'd16);
    chk("run_led_blinks", 64'(led_toggles > 0), 64'd1);
    chk("done_ready", 64'(ready_out), 64'd1);
    chk("done_led", 64'(status_led_n_out), 64'd0);
    chk("done_busy", 64'(busy_out), 64'd0);

    // Stop on first match at RUN cycle 5.
    load_job(1'b1);
    chk("stop_run_core", 64'(core_reset_n_out), 64'd1);
    repeat (5) step();
    strobe(32'h0000_00A5, 8'h01, 1'b0);
    chk("stop_busy", 64'(busy_out), 64'd0);
    chk("stop_core", 64'(core_reset_n_out), 64'd0);
    chk("stop_head", 64'(result_data_out), 64'h01_0000_00A5);
    chk("stop_count", 64'(result_count_out), 64'd1);
    chk("stop_ready", 64'(ready_out), 64'd1);

    // Collect-all overflow with five strobes.
    load_job(1'b0);
    for (int i = 0; i < 5; i++) strobe(32'h10 + 32'(i), 8'hF0 + 8'(i), 1'b0);
    chk("ovf_count", 64'(result_count_out), 64'd4);
    chk("ovf_flag", 64'(overflow_out), 64'd1);
    chk("ovf_head0", 64'(result_data_out), 64'hF0_0000_0010);
    pop_one();
    chk("ovf_head1", 64'(result_data_out), 64'hF1_0000_0011);
    pop_one();
    chk("ovf_head2", 64'(result_data_out), 64'hF2_0000_0012);
    pop_one();
    chk("ovf_head3", 64'(result_data_out), 64'hF3_0000_0013);
    pop_one();
    chk("ovf_empty_valid", 64'(result_valid_out), 64'd0);
    chk("ovf_empty_ready", 64'(ready_out), 64'd0);
    pop_one();
    chk("pop_empty_count", 64'(result_count_out), 64'd0);

    // New job clears overflow; full FIFO push+pop keeps count and no overflow.
    load_job(1'b0);
    chk("reload_ovf", 64'(overflow_out), 64'd0);
    chk("reload_count", 64'(result_count_out), 64'd0);
    for (int i = 0; i < 4; i++) strobe(32'h20 + 32'(i), 8'h40 + 8'(i), 1'b0);
    chk("full_count", 64'(result_count_out), 64'd4);
    strobe(32'h24, 8'h44, 1'b1);
    chk("pushpop_count", 64'(result_count_out), 64'd4);
    chk("pushpop_ovf", 64'(overflow_out), 64'd0);
    chk("pushpop_head", 64'(result_data_out), 64'h41_0000_0021);

    // Abort at RUN cycle 3, then load+abort together.
    load_job(1'b0);
    repeat (3) step();
    job_abort_in = 1'b1;
    step();
    job_abort_in = 1'b0;
    chk("abort_busy", 64'(busy_out), 64'd0);
    chk("abort_core", 64'(core_reset_n_out), 64'd0);
    chk("abort_ready", 64'(ready_out), 64'd1);
    job_load_in  = 1'b1;
    job_abort_in = 1'b1;
    step();
    job_load_in  = 1'b0;
    job_abort_in = 1'b0;
    chk("ldab_busy", 64'(busy_out), 64'd1);
    chk("ldab_ready", 64'(ready_out), 64'd0);
    repeat (4) step();
    chk("ldab_run_core", 64'(core_reset_n_out), 64'd1);

    // Success on the final RUN cycle is kept; strobes in DONE are ignored.
    load_job(1'b0);
    repeat (15) step();
    strobe(32'h0000_0077, 8'h07, 1'b0);
    chk("last_busy", 64'(busy_out), 64'd0);
    chk("last_count", 64'(result_count_out), 64'd1);
    chk("last_head", 64'(result_data_out), 64'h07_0000_0077);
    strobe(32'h0000_0088, 8'h08, 1'b0);
    chk("done_ignore_count", 64'(result_count_out), 64'd1);

    // Reset mid-run with two results held.
    load_job(1'b0);
    strobe(32'h1, 8'h1, 1'b0);
    strobe(32'h2, 8'h2, 1'b0);
    chk("midrst_count_pre", 64'(result_count_out), 64'd2);
    reset_n_in = 1'b0;
    step();
    check_reset("midrst");
    reset_n_in = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
